game_screen_loader: RTL
=======================

GAME_SCREEN_LOADER -- requirements
Module: game_screen_loader

Interface
REQ-001 Parameter H_RES, default 640, pixels per line.
REQ-002 Parameter V_RES, default 480, lines per frame; H_RES*V_RES SHALL NOT exceed 2^19.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 init, menu, battle, casual, restart  input  1 each  game FSM mode flags.
REQ-006 redraw  input  1  single-cycle request to redraw the current screen.
REQ-007 ram_address  output  19  image RAM read address.
REQ-008 ram_data  input  3  image RAM colour, valid exactly 1 cycle after ram_address.
REQ-009 screen_sel  output  2  image select to RAM bank: 0 START, 1 MENU, 2 GAME, 3 RESTART.
REQ-010 vga_x  output  10, vga_y  output  9, vga_colour  output  3  pixel to plot.
REQ-011 vga_plot  output  1  pixel valid; vga_ready  input  1  adapter accepts pixel when vga_plot && vga_ready.
REQ-012 busy  output  1  high while a frame is being drawn; done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 Requested mode SHALL be decoded by priority: init->START, else menu->MENU, else battle|casual->GAME, else restart->RESTART, else START.
REQ-014 States SHALL be IDLE, DRAW, FINISH.
REQ-015 IDLE->DRAW when redraw=1, when pending=1, or when requested mode differs from screen_sel; on entry screen_sel<=requested mode, pixel counter (x,y,address)<=0, pending<=0.
REQ-016 In DRAW the controller SHALL issue ram_address=y*H_RES+x, generated by incrementing a counter, never by multiplication.
REQ-017 The output stage SHALL register x, y one cycle after issue and present ram_data as vga_colour with vga_plot=1.
REQ-018 Address SHALL advance only when the output stage is empty or being accepted in the same cycle; while vga_plot=1 and vga_ready=0, vga_x/vga_y/vga_colour/ram_address SHALL hold stable.
REQ-019 At full throughput (vga_ready=1) one pixel SHALL be accepted per cycle; first vga_plot SHALL rise exactly 2 cycles after the IDLE->DRAW decision cycle.
REQ-020 x SHALL wrap H_RES-1->0 with y incrementing; after issuing (H_RES-1, V_RES-1) no further address is issued.
REQ-021 DRAW->FINISH when the last pixel is accepted; FINISH SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 Pixels SHALL be plotted in raster order, each exactly once per completed frame.
REQ-023 Requested-mode change during DRAW SHALL abort: vga_plot deasserted next cycle (in-flight pixel discarded), screen_sel updated, counter reset to 0, draw restarted without passing through FINISH; no done pulse for the aborted frame.
REQ-024 redraw during DRAW with unchanged mode SHALL set pending; the frame completes normally, then a new frame starts from IDLE.
REQ-025 redraw in FINISH SHALL set pending; simultaneous redraw and mode change SHALL be treated as mode change.
REQ-026 busy SHALL equal 1 in DRAW and 0 in IDLE and FINISH.
REQ-027 ram_address SHALL be 0 and vga_plot 0 in IDLE.

Reset
REQ-028 On reset: state IDLE, screen_sel=0, pending=1, counter=0, ram_address=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0.
REQ-029 After reset release, a START frame SHALL begin automatically due to pending=1.
REQ-030 Reset asserted mid-frame SHALL immediately clear all outputs per REQ-028 with no done pulse.

Verification (H_RES=4, V_RES=3, RAM model returns address[2:0])
REQ-031 Reset release, all mode flags 0, vga_ready=1 -> screen_sel=0, 12 plots (0,0)..(3,2), colours 0..7,0..3, done pulse 1 cycle after last plot, busy low after.
REQ-032 vga_ready toggled 1,0,0,1 repeatedly -> same 12 pixels in order, none duplicated or lost, outputs stable while stalled.
REQ-033 menu=1 raised at pixel 5 of START frame -> vga_plot low next cycle, screen_sel=1, restart at (0,0), one done only at end of MENU frame.
REQ-034 init=1 and battle=1 together -> screen_sel=0; battle alone -> screen_sel=2; restart alone -> screen_sel=3.
REQ-035 redraw pulsed mid-frame -> current frame completes with done, second identical frame follows immediately.
REQ-036 reset pulsed at pixel 7 -> all outputs 0 asynchronously, no done, fresh START frame after release.

Source files
------------

// File: rtl/game_screen_loader.sv
// Streams a full-screen image from image RAM to a VGA pixel adapter, one pixel per
// accepted handshake, re-drawing whenever the game mode changes or a redraw is requested.
module game_screen_loader #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        menu,
  input  logic        battle,
  input  logic        casual,
  input  logic        restart,
  input  logic        redraw,
  output logic [18:0] ram_address,
  input  logic [2:0]  ram_data,
  output logic [1:0]  screen_sel,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  input  logic        vga_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned C_W    = 3;
  localparam int unsigned SEL_W  = 2;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  localparam logic [SEL_W-1:0] SCR_START   = 2'd0;
  localparam logic [SEL_W-1:0] SCR_MENU    = 2'd1;
  localparam logic [SEL_W-1:0] SCR_GAME    = 2'd2;
  localparam logic [SEL_W-1:0] SCR_RESTART = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              pending_q, pending_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue_vld_q, issue_vld_d;
  logic [X_W-1:0]    out_x_q, out_x_d;
  logic [Y_W-1:0]    out_y_q, out_y_d;
  logic              plot_q, plot_d;
  logic              fresh_q, fresh_d;
  logic [C_W-1:0]    col_hold_q, col_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  req_mode_c;
  logic              mode_chg_c;
  logic              advance_c;
  logic              last_issue_c;
  logic              last_accept_c;

  // Priority decode of the game FSM flags into a screen image
  always_comb begin
    req_mode_c = SCR_START;
    if (init)                 req_mode_c = SCR_START;
    else if (menu)            req_mode_c = SCR_MENU;
    else if (battle || casual) req_mode_c = SCR_GAME;
    else if (restart)         req_mode_c = SCR_RESTART;
  end

  // Pipeline handshake: issue stage moves only when the output stage frees up
  always_comb begin
    mode_chg_c    = (req_mode_c != sel_q);
    advance_c     = issue_vld_q && (!plot_q || vga_ready);
    last_issue_c  = (x_q == X_LAST) && (y_q == Y_LAST);
    last_accept_c = plot_q && vga_ready && (out_x_q == X_LAST) && (out_y_q == Y_LAST);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pending_d   = pending_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    issue_vld_d = issue_vld_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    plot_d      = plot_q;
    fresh_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // RAM data is only valid the cycle after the pixel lands in the output stage
    col_hold_d  = fresh_q ? ram_data : col_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (redraw || pending_q || mode_chg_c) begin
          state_d     = S_DRAW;
          sel_d       = req_mode_c;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          issue_vld_d = 1'b1;
          pending_d   = 1'b0;
          busy_d      = 1'b1;
        end
      end

      S_DRAW: begin
        if (mode_chg_c) begin
          // Abort: drop the in-flight pixel and restart the new image from the origin
          sel_d       = req_mode_c;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          issue_vld_d = 1'b1;
          plot_d      = 1'b0;
          pending_d   = 1'b0;
        end else begin
          if (redraw) pending_d = 1'b1;
          if (plot_q && vga_ready) plot_d = 1'b0;
          if (advance_c) begin
            out_x_d = x_q;
            out_y_d = y_q;
            plot_d  = 1'b1;
            fresh_d = 1'b1;
            if (last_issue_c) begin
              issue_vld_d = 1'b0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
              end else begin
                x_d = x_q + X_W'(1);
              end
            end
          end
          if (last_accept_c) begin
            state_d     = S_FINISH;
            plot_d      = 1'b0;
            issue_vld_d = 1'b0;
            addr_d      = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

      S_FINISH: begin
        if (redraw) pending_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        plot_d      = 1'b0;
        issue_vld_d = 1'b0;
        addr_d      = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= SCR_START;
      pending_q   <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      issue_vld_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      plot_q      <= 1'b0;
      fresh_q     <= 1'b0;
      col_hold_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      issue_vld_q <= issue_vld_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      plot_q      <= plot_d;
      fresh_q     <= fresh_d;
      col_hold_q  <= col_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_address = addr_q;
  assign screen_sel  = sel_q;
  assign vga_x       = out_x_q;
  assign vga_y       = out_y_q;
  assign vga_plot    = plot_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign vga_colour  = fresh_q ? ram_data : col_hold_q;

endmodule
